// File: rtl/basic_gates_pkg.sv
// ---------------------------------------------------------------------------
// basic_gates_pkg
//
// Purpose: shared definitions for the basic_gates logic unit.
//   DEFAULT_WIDTH : default operand/result width of basic_gates.
//   NUM_GATE_OPS  : number of gate functions the unit produces.
//   gate_op_e     : names each of the seven gate outputs so that results
//                   can be indexed symbolically.
// ---------------------------------------------------------------------------
package basic_gates_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int NUM_GATE_OPS  = 7;

    typedef enum logic [2:0] {
        AND  = 3'd0,
        OR   = 3'd1,
        NOT  = 3'd2,
        XOR  = 3'd3,
        NAND = 3'd4,
        NOR  = 3'd5,
        XNOR = 3'd6
    } gate_op_e;

endpackage : basic_gates_pkg

// File: rtl/gate_bit_slice.sv
// ---------------------------------------------------------------------------
// gate_bit_slice
//
// Purpose: one-bit combinational cell that produces all seven basic gate
// functions of a single operand bit pair.
//
// Ports:
//   a, b    : operand bits.
//   and_o   : a & b
//   or_o    : a | b
//   not_o   : ~a (b ignored)
//   xor_o   : a ^ b
//   nand_o  : ~(a & b)
//   nor_o   : ~(a | b)
//   xnor_o  : ~(a ^ b)
// ---------------------------------------------------------------------------
module gate_bit_slice
    import basic_gates_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic and_o,
    output logic or_o,
    output logic not_o,
    output logic xor_o,
    output logic nand_o,
    output logic nor_o,
    output logic xnor_o
);

    // The inverted outputs are derived from their true forms so the
    // complement relationships hold by construction.
    always_comb begin
        and_o  = a & b;
        or_o   = a | b;
        not_o  = ~a;
        xor_o  = a ^ b;
        nand_o = ~and_o;
        nor_o  = ~or_o;
        xnor_o = ~xor_o;
    end

endmodule : gate_bit_slice

// File: rtl/basic_gates.sv
// ---------------------------------------------------------------------------
// basic_gates
//
// Purpose: bit-wise logic gate unit. Replicates gate_bit_slice WIDTH times
// and optionally registers all seven results (1-cycle latency).
//
// Parameters:
//   WIDTH      : operand/result width, 1..64.
//   REGISTERED : 1 = registered outputs with synchronous active-low reset,
//                0 = purely combinational (clk/rst_n unused).
//
// Ports:
//   clk        : rising-edge clock (registered build only).
//   rst_n      : synchronous active-low reset (registered build only).
//   A, B       : operands.
//   and_gate .. xnor_gate : A&B, A|B, ~A, A^B, ~(A&B), ~(A|B), ~(A^B).
// ---------------------------------------------------------------------------
module basic_gates
    import basic_gates_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] and_gate,
    output logic [WIDTH-1:0] or_gate,
    output logic [WIDTH-1:0] not_gate,
    output logic [WIDTH-1:0] xor_gate,
    output logic [WIDTH-1:0] nand_gate,
    output logic [WIDTH-1:0] nor_gate,
    output logic [WIDTH-1:0] xnor_gate
);

    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] or_s;
    logic [WIDTH-1:0] not_s;
    logic [WIDTH-1:0] xor_s;
    logic [WIDTH-1:0] nand_s;
    logic [WIDTH-1:0] nor_s;
    logic [WIDTH-1:0] xnor_s;

    // Each result bit depends only on the matching operand bits, so the
    // datapath is just WIDTH independent slices.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        gate_bit_slice u_slice (
            .a      (A[i]),
            .b      (B[i]),
            .and_o  (and_s[i]),
            .or_o   (or_s[i]),
            .not_o  (not_s[i]),
            .xor_o  (xor_s[i]),
            .nand_o (nand_s[i]),
            .nor_o  (nor_s[i]),
            .xnor_o (xnor_s[i])
        );
    end

    if (REGISTERED) begin : g_registered
        logic [WIDTH-1:0] and_d,  and_q;
        logic [WIDTH-1:0] or_d,   or_q;
        logic [WIDTH-1:0] not_d,  not_q;
        logic [WIDTH-1:0] xor_d,  xor_q;
        logic [WIDTH-1:0] nand_d, nand_q;
        logic [WIDTH-1:0] nor_d,  nor_q;
        logic [WIDTH-1:0] xnor_d, xnor_q;

        // Next-state values are simply the slice results of the current
        // operands; the register stage adds no other logic.
        always_comb begin
            and_d  = and_s;
            or_d   = or_s;
            not_d  = not_s;
            xor_d  = xor_s;
            nand_d = nand_s;
            nor_d  = nor_s;
            xnor_d = xnor_s;
        end

        // Reset clears every output to zero, including the inverted ones,
        // and discards whatever result was being captured at that edge.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                and_q  <= '0;
                or_q   <= '0;
                not_q  <= '0;
                xor_q  <= '0;
                nand_q <= '0;
                nor_q  <= '0;
                xnor_q <= '0;
            end else begin
                and_q  <= and_d;
                or_q   <= or_d;
                not_q  <= not_d;
                xor_q  <= xor_d;
                nand_q <= nand_d;
                nor_q  <= nor_d;
                xnor_q <= xnor_d;
            end
        end

        assign and_gate  = and_q;
        assign or_gate   = or_q;
        assign not_gate  = not_q;
        assign xor_gate  = xor_q;
        assign nand_gate = nand_q;
        assign nor_gate  = nor_q;
        assign xnor_gate = xnor_q;
    end else begin : g_combinational
        // Clock and reset have no function in this build; they are folded
        // into a dummy signal so the ports stay in place.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};

        assign and_gate  = and_s;
        assign or_gate   = or_s;
        assign not_gate  = not_s;
        assign xor_gate  = xor_s;
        assign nand_gate = nand_s;
        assign nor_gate  = nor_s;
        assign xnor_gate = xnor_s;
    end

endmodule : basic_gates

// File: tb/tb_basic_gates.sv
// ---------------------------------------------------------------------------
// tb_basic_gates
//
// Directed testbench for basic_gates. Three instances are exercised:
//   u_dut1 : WIDTH=1, REGISTERED=1 (reset, truth table, latency, mid reset)
//   u_dut8 : WIDTH=8, REGISTERED=1 (multi-bit vector)
//   u_dutc : WIDTH=1, REGISTERED=0 (combinational build, clock held low)
// ---------------------------------------------------------------------------
module tb_basic_gates;
    import basic_gates_pkg::*;

    int vectors    = 0;
    int miscompares = 0;

    logic clk = 1'b0;
    logic rst_n;
    logic comb_clk = 1'b0;
    logic comb_rst_n = 1'b1;

    // Clock: posedge at 5, 15, 25 ... ; negedges used for drive and sample.
    always #5 clk = ~clk;

    // ---------------- WIDTH=1 registered ----------------
    logic a1, b1;
    logic and1, or1, not1, xor1, nand1, nor1, xnor1;
    logic [6:0] r1;
    assign r1 = {and1, or1, not1, xor1, nand1, nor1, xnor1};

    basic_gates #(.WIDTH(1), .REGISTERED(1'b1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a1),
        .B         (b1),
        .and_gate  (and1),
        .or_gate   (or1),
        .not_gate  (not1),
        .xor_gate  (xor1),
        .nand_gate (nand1),
        .nor_gate  (nor1),
        .xnor_gate (xnor1)
    );

    // ---------------- WIDTH=8 registered ----------------
    logic [7:0] a8, b8;
    logic [7:0] and8, or8, not8, xor8, nand8, nor8, xnor8;

    basic_gates #(.WIDTH(8), .REGISTERED(1'b1)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a8),
        .B         (b8),
        .and_gate  (and8),
        .or_gate   (or8),
        .not_gate  (not8),
        .xor_gate  (xor8),
        .nand_gate (nand8),
        .nor_gate  (nor8),
        .xnor_gate (xnor8)
    );

    // ---------------- WIDTH=1 combinational ----------------
    logic ca, cb;
    logic andc, orc, notc, xorc, nandc, norc, xnorc;
    logic [6:0] rc;
    assign rc = {andc, orc, notc, xorc, nandc, norc, xnorc};

    basic_gates #(.WIDTH(1), .REGISTERED(1'b0)) u_dutc (
        .clk       (comb_clk),
        .rst_n     (comb_rst_n),
        .A         (ca),
        .B         (cb),
        .and_gate  (andc),
        .or_gate   (orc),
        .not_gate  (notc),
        .xor_gate  (xorc),
        .nand_gate (nandc),
        .nor_gate  (norc),
        .xnor_gate (xnorc)
    );

    // Expected 1-bit results packed as {and,or,not,xor,nand,nor,xnor},
    // indexed by {A,B}.
    logic [6:0] truth [4];
    // Expected 8-bit results for A=F0, B=CC, indexed by gate_op_e.
    logic [7:0] exp8 [NUM_GATE_OPS];

    function automatic logic [7:0] pick8(input gate_op_e op);
        logic [7:0] v;
        v = '0;
        case (op)
            AND:     v = and8;
            OR:      v = or8;
            NOT:     v = not8;
            XOR:     v = xor8;
            NAND:    v = nand8;
            NOR:     v = nor8;
            XNOR:    v = xnor8;
            default: v = 'x;
        endcase
        return v;
    endfunction

    // Drive the 1-bit registered DUT at a negedge and let one edge pass.
    task automatic applyStimulus(input logic a_in, input logic b_in, input logic rst_in);
        a1    = a_in;
        b1    = b_in;
        rst_n = rst_in;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    initial begin
        truth[0] = 7'b0010111;  // 00
        truth[1] = 7'b0111100;  // 01
        truth[2] = 7'b0101100;  // 10
        truth[3] = 7'b1100001;  // 11

        exp8[AND]  = 8'hC0;
        exp8[OR]   = 8'hFC;
        exp8[NOT]  = 8'h0F;
        exp8[XOR]  = 8'h3C;
        exp8[NAND] = 8'h3F;
        exp8[NOR]  = 8'h03;
        exp8[XNOR] = 8'hC3;

        a8 = 8'hF0;
        b8 = 8'hCC;
        ca = 1'b0;
        cb = 1'b0;

        // Reset held with A=B=1 for two edges: everything reads zero.
        a1    = 1'b1;
        b1    = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_hold_1", 64'(r1), 64'(7'b0));
        @(negedge clk);
        checkOutput("reset_hold_2", 64'(r1), 64'(7'b0));
        checkOutput("reset_w8_not", 64'(not8), 64'(8'h00));
        checkOutput("reset_w8_xnor", 64'(xnor8), 64'(8'h00));

        // First edge with rst_n high produces the 11 result.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("release_11", 64'(r1), 64'(truth[3]));

        // 8-bit vector, captured on the same release edge.
        for (int i = 0; i < NUM_GATE_OPS; i++) begin
            gate_op_e op;
            op = gate_op_e'(i);
            checkOutput({"w8_", op.name()}, 64'(pick8(op)), 64'(exp8[op]));
        end

        // Exhaustive truth table on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            applyStimulus(ab[1], ab[0], 1'b1);
            checkOutput($sformatf("truth_%b", ab), 64'(r1), 64'(truth[i]));
        end

        // Operand changes between edges: only the value at the edge counts.
        a1 = 1'b0; b1 = 1'b0;
        #2;
        a1 = 1'b0; b1 = 1'b1;
        #2;
        a1 = 1'b1; b1 = 1'b0;
        checkOutput("between_edges_hold", 64'(r1), 64'(truth[3]));
        @(negedge clk);
        checkOutput("latency_10", 64'(r1), 64'(truth[2]));

        // Reset during the middle of a stream discards the 01 result.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("stream_11", 64'(r1), 64'(truth[3]));
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stream_reset_01", 64'(r1), 64'(7'b0));
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("stream_after_10", 64'(r1), 64'(truth[2]));

        // Combinational build: no clock, outputs settle in the same step.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            ca = ab[1];
            cb = ab[0];
            #1;
            checkOutput($sformatf("comb_%b", ab), 64'(rc), 64'(truth[i]));
            #9;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_basic_gates
